// File: rtl/ram_arbiter.sv
// Two-port (CPU, loader) round-robin arbiter in front of a single-port synchronous RAM.
// One access at a time: IDLE -> ACC -> [RD x RD_LAT] -> ACK -> IDLE, with every output registered.
module ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACC, RD, ACK} state_t;

    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    state_t            state;
    logic              we_flag;
    logic [1:0]        rd_cnt;
    logic              grant_any;
    logic              grant_ld;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    // On a tie the port that was not served last wins; owner resets to 1 so the CPU wins first.
    always_comb begin
        grant_any   = cpu_req | ld_req;
        grant_ld    = ld_req & (~cpu_req | ~owner);
        grant_we    = grant_ld ? ld_we    : cpu_we;
        grant_addr  = grant_ld ? ld_addr  : cpu_addr;
        grant_wdata = grant_ld ? ld_wdata : cpu_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            we_flag   <= 1'b0;
            rd_cnt    <= 2'd0;
            ram_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            busy      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
            owner     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ack <= 1'b0;
                    ld_ack  <= 1'b0;
                    if (grant_any) begin
                        owner     <= grant_ld;
                        ram_addr  <= grant_addr;
                        ram_wdata <= grant_wdata;
                        we_flag   <= grant_we;
                        ram_we    <= grant_we;
                        busy      <= 1'b1;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    ram_we <= 1'b0;
                    if (we_flag) begin
                        cpu_ack <= ~owner;
                        ld_ack  <= owner;
                        state   <= ACK;
                    end else begin
                        rd_cnt <= 2'd0;
                        state  <= RD;
                    end
                end
                RD: begin
                    // RAM data for the address presented in ACC is valid on the last RD edge.
                    if (rd_cnt == RD_LAST) begin
                        if (owner) begin
                            ld_rdata <= ram_rdata;
                        end else begin
                            cpu_rdata <= ram_rdata;
                        end
                        cpu_ack <= ~owner;
                        ld_ack  <= owner;
                        state   <= ACK;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                ACK: begin
                    cpu_ack <= 1'b0;
                    ld_ack  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one instance with RD_LAT=1, one with RD_LAT=3, each with a RAM model.
// Expected completions are queued when requests are driven and popped when an ack appears.
module tb_ram_arbiter;

    typedef struct {
        logic       port;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          total;
    int          bad;
    exp_t        q1[$];
    exp_t        q3[$];
    exp_t        m;
    logic [7:0]  got;

    // instance with RD_LAT = 1
    logic        c_req, c_we, l_req, l_we;
    logic [15:0] c_addr, l_addr;
    logic [7:0]  c_wdata, l_wdata;
    logic [7:0]  cpu_rdata1, ld_rdata1, ram_wdata1, ram_rdata1;
    logic        cpu_ack1, ld_ack1, ram_we1, busy1, owner1;
    logic [15:0] ram_addr1;

    // instance with RD_LAT = 3
    logic        c_req3, c_we3, l_req3, l_we3;
    logic [15:0] c_addr3, l_addr3;
    logic [7:0]  c_wdata3, l_wdata3;
    logic [7:0]  cpu_rdata3, ld_rdata3, ram_wdata3, ram_rdata3;
    logic        cpu_ack3, ld_ack3, ram_we3, busy3, owner3;
    logic [15:0] ram_addr3;

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
        .ld_req(l_req), .ld_we(l_we), .ld_addr(l_addr), .ld_wdata(l_wdata),
        .ld_rdata(ld_rdata1), .ld_ack(ld_ack1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_rdata(ram_rdata1),
        .busy(busy1), .owner(owner1)
    );

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst_n),
        .cpu_req(c_req3), .cpu_we(c_we3), .cpu_addr(c_addr3), .cpu_wdata(c_wdata3),
        .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
        .ld_req(l_req3), .ld_we(l_we3), .ld_addr(l_addr3), .ld_wdata(l_wdata3),
        .ld_rdata(ld_rdata3), .ld_ack(ld_ack3),
        .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_we(ram_we3), .ram_rdata(ram_rdata3),
        .busy(busy3), .owner(owner3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h0200: return 8'h3C;
            16'hFFFF: return 8'h81;
            16'h0100: return 8'h11;
            16'h0101: return 8'h22;
            default:  return a[7:0] ^ a[15:8];
        endcase
    endfunction

    function automatic exp_t mk(input logic port, input logic rd, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

    // RAM models: unwritten locations return init_val
    bit [7:0] mem1 [0:65535];
    bit       wr1  [0:65535];
    bit [7:0] mem3 [0:65535];
    bit       wr3  [0:65535];
    logic [7:0] p3a, p3b;

    always @(posedge clk) begin
        ram_rdata1 <= wr1[ram_addr1] ? mem1[ram_addr1] : init_val(ram_addr1);
        if (ram_we1) begin
            mem1[ram_addr1] <= ram_wdata1;
            wr1[ram_addr1]  <= 1'b1;
        end
    end

    always @(posedge clk) begin
        p3a        <= wr3[ram_addr3] ? mem3[ram_addr3] : init_val(ram_addr3);
        p3b        <= p3a;
        ram_rdata3 <= p3b;
        if (ram_we3) begin
            mem3[ram_addr3] <= ram_wdata3;
            wr3[ram_addr3]  <= 1'b1;
        end
    end

    // scoreboard: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && (cpu_ack1 || ld_ack1)) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL sb1_unexpected: cpu_ack=%0b ld_ack=%0b, required no ack", cpu_ack1, ld_ack1);
            end else begin
                m   = q1.pop_front();
                got = ld_ack1 ? ld_rdata1 : cpu_rdata1;
                if ((cpu_ack1 && ld_ack1) || ld_ack1 !== m.port || (m.rd && got !== m.data)) begin
                    bad++;
                    $display("FAIL sb1_ack: acks=%0b%0b data=%h, required port=%0b data=%h",
                             cpu_ack1, ld_ack1, got, m.port, m.data);
                end
            end
        end
        if (rst_n && (cpu_ack3 || ld_ack3)) begin
            total++;
            if (q3.size() == 0) begin
                bad++;
                $display("FAIL sb3_unexpected: cpu_ack=%0b ld_ack=%0b, required no ack", cpu_ack3, ld_ack3);
            end else begin
                m   = q3.pop_front();
                got = ld_ack3 ? ld_rdata3 : cpu_rdata3;
                if ((cpu_ack3 && ld_ack3) || ld_ack3 !== m.port || (m.rd && got !== m.data)) begin
                    bad++;
                    $display("FAIL sb3_ack: acks=%0b%0b data=%h, required port=%0b data=%h",
                             cpu_ack3, ld_ack3, got, m.port, m.data);
                end
            end
        end
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ram_we1, cpu_ack1, ld_ack1, busy1, owner1} !== 5'b00001) begin
            bad++;
            $display("FAIL rst_ctrl1: got=%b required=00001", {ram_we1, cpu_ack1, ld_ack1, busy1, owner1});
        end
        total++;
        if ({ram_addr1, ram_wdata1, cpu_rdata1, ld_rdata1} !== 40'h0) begin
            bad++;
            $display("FAIL rst_data1: got=%h required=0", {ram_addr1, ram_wdata1, cpu_rdata1, ld_rdata1});
        end
        total++;
        if ({busy3, owner3, cpu_rdata3} !== 10'b01_0000_0000) begin
            bad++;
            $display("FAIL rst_dut3: got=%b required=0100000000", {busy3, owner3, cpu_rdata3});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_cpu_write();
        int we_cnt = 0;
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0010; c_wdata = 8'hA5;
        q1.push_back(mk(1'b0, 1'b0, 8'h00));
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (ram_we1) we_cnt++;
            if (c == 1) begin
                total++;
                if ({ram_we1, ram_addr1, ram_wdata1} !== {1'b1, 16'h0010, 8'hA5}) begin
                    bad++;
                    $display("FAIL wr_acc: we=%0b addr=%h wdata=%h, required 1/0010/a5", ram_we1, ram_addr1, ram_wdata1);
                end
            end
            total++;
            if (cpu_ack1 !== (c == 2) || ld_ack1 !== 1'b0) begin
                bad++;
                $display("FAIL wr_ack cycle %0d: cpu_ack=%0b ld_ack=%0b, required %0b/0", c, cpu_ack1, ld_ack1, c == 2);
            end
            if (c == 2) begin
                @(posedge clk); #1 c_req = 1'b0;
            end
        end
        total++;
        if (we_cnt != 1) begin
            bad++;
            $display("FAIL wr_we_count: got=%0d required=1", we_cnt);
        end
    endtask

    task automatic test_ld_read();
        @(posedge clk); #1;
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0200;
        q1.push_back(mk(1'b1, 1'b1, 8'h3C));
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if (ld_ack1 !== (c == 3) || cpu_ack1 !== 1'b0 || ram_we1 !== 1'b0) begin
                bad++;
                $display("FAIL ldrd_ctrl cycle %0d: ld_ack=%0b cpu_ack=%0b ram_we=%0b, required %0b/0/0",
                         c, ld_ack1, cpu_ack1, ram_we1, c == 3);
            end
            total++;
            if (cpu_rdata1 !== 8'h00) begin
                bad++;
                $display("FAIL ldrd_cpu_rdata cycle %0d: got=%h required=00", c, cpu_rdata1);
            end
            if (c == 3) begin
                total++;
                if (ld_rdata1 !== 8'h3C) begin
                    bad++;
                    $display("FAIL ldrd_data: got=%h required=3c", ld_rdata1);
                end
                @(posedge clk); #1 l_req = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int         ack_at[3] = '{3, 6, 10};
        logic [7:0] rd_at[3]  = '{8'hA5, 8'hA5, 8'h77};
        int         k = 0;
        logic       exp_ack;
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        q1.push_back(mk(1'b0, 1'b1, 8'hA5));
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            exp_ack = (k < 3) && (c == ack_at[k]);
            total++;
            if (cpu_ack1 !== exp_ack || busy1 !== (c != 4 && c != 7 && c <= 10)) begin
                bad++;
                $display("FAIL b2b_ctrl cycle %0d: cpu_ack=%0b busy=%0b, required %0b/%0b",
                         c, cpu_ack1, busy1, exp_ack, c != 4 && c != 7 && c <= 10);
            end
            total++;
            if (ld_rdata1 !== 8'h3C) begin
                bad++;
                $display("FAIL b2b_ld_rdata cycle %0d: got=%h required=3c", c, ld_rdata1);
            end
            if (exp_ack) begin
                total++;
                if (cpu_rdata1 !== rd_at[k]) begin
                    bad++;
                    $display("FAIL b2b_cpu_rdata cycle %0d: got=%h required=%h", c, cpu_rdata1, rd_at[k]);
                end
                k++;
                @(posedge clk); #1;
                if (k == 1) begin
                    c_we = 1'b1; c_addr = 16'h0011; c_wdata = 8'h77;
                    q1.push_back(mk(1'b0, 1'b0, 8'h00));
                end else if (k == 2) begin
                    c_we = 1'b0; c_addr = 16'h0011;
                    q1.push_back(mk(1'b0, 1'b1, 8'h77));
                end else begin
                    c_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_hold_off();
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0030; c_wdata = 8'h42;
        q1.push_back(mk(1'b0, 1'b0, 8'h00));
        @(posedge clk); #1;
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0200;
        q1.push_back(mk(1'b1, 1'b1, 8'h3C));
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            total++;
            if ({cpu_ack1, ld_ack1, busy1, owner1} !== {c == 2, c == 6, c != 3 && c <= 6, c >= 4}) begin
                bad++;
                $display("FAIL hold_ctrl cycle %0d: ack=%0b%0b busy=%0b owner=%0b, required %0b%0b %0b %0b",
                         c, cpu_ack1, ld_ack1, busy1, owner1, c == 2, c == 6, c != 3 && c <= 6, c >= 4);
            end
            if (c == 2) begin
                @(posedge clk); #1 c_req = 1'b0;
            end else if (c == 6) begin
                @(posedge clk); #1 l_req = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        logic eo;
        logic slot;
        @(posedge clk); #1;
        rst_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0100;
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0101;
        q1.push_back(mk(1'b0, 1'b1, 8'h11));
        q1.push_back(mk(1'b1, 1'b1, 8'h22));
        q1.push_back(mk(1'b0, 1'b1, 8'h11));
        q1.push_back(mk(1'b1, 1'b1, 8'h22));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (owner1 !== 1'b1 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL rr_start: owner=%0b busy=%0b, required 1/0", owner1, busy1);
        end
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            eo   = 1'(((c - 1) / 4) % 2);
            slot = (c % 4 == 3);
            total++;
            if (owner1 !== eo || busy1 !== (c % 4 != 0)) begin
                bad++;
                $display("FAIL rr_owner cycle %0d: owner=%0b busy=%0b, required %0b/%0b", c, owner1, busy1, eo, c % 4 != 0);
            end
            total++;
            if ({cpu_ack1, ld_ack1} !== {slot && !eo, slot && eo}) begin
                bad++;
                $display("FAIL rr_ack cycle %0d: acks=%0b%0b, required %0b%0b", c, cpu_ack1, ld_ack1, slot && !eo, slot && eo);
            end
            if (c == 15) begin
                @(posedge clk); #1;
                c_req = 1'b0; l_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0020; c_wdata = 8'h5A;
        @(posedge clk); #2;
        total++;
        if (ram_we1 !== 1'b1) begin
            bad++;
            $display("FAIL mid_acc_we: got=%0b required=1", ram_we1);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ram_we1, cpu_ack1, ld_ack1, busy1, owner1} !== 5'b00001) begin
            bad++;
            $display("FAIL mid_rst_ctrl: got=%b required=00001", {ram_we1, cpu_ack1, ld_ack1, busy1, owner1});
        end
        total++;
        if ({ram_addr1, ram_wdata1, cpu_rdata1, ld_rdata1} !== 40'h0) begin
            bad++;
            $display("FAIL mid_rst_data: got=%h required=0", {ram_addr1, ram_wdata1, cpu_rdata1, ld_rdata1});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        q1.push_back(mk(1'b0, 1'b0, 8'h00));
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++;
                if ({ram_we1, ram_addr1, ram_wdata1} !== {1'b1, 16'h0020, 8'h5A}) begin
                    bad++;
                    $display("FAIL mid_retry_acc: we=%0b addr=%h wdata=%h, required 1/0020/5a", ram_we1, ram_addr1, ram_wdata1);
                end
            end
            total++;
            if (cpu_ack1 !== (c == 2)) begin
                bad++;
                $display("FAIL mid_retry_ack cycle %0d: got=%0b required=%0b", c, cpu_ack1, c == 2);
            end
            if (c == 2) begin
                @(posedge clk); #1 c_req = 1'b0;
            end
        end
    endtask

    task automatic test_rdlat3();
        @(posedge clk); #1;
        c_req3 = 1'b1; c_we3 = 1'b0; c_addr3 = 16'hFFFF;
        q3.push_back(mk(1'b0, 1'b1, 8'h81));
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            total++;
            if (busy3 !== (c <= 5) || cpu_ack3 !== (c == 5) || ld_ack3 !== 1'b0) begin
                bad++;
                $display("FAIL lat3_ctrl cycle %0d: busy=%0b cpu_ack=%0b ld_ack=%0b, required %0b/%0b/0",
                         c, busy3, cpu_ack3, ld_ack3, c <= 5, c == 5);
            end
            if (c == 1) begin
                total++;
                if (owner3 !== 1'b0) begin
                    bad++;
                    $display("FAIL lat3_owner: got=%0b required=0", owner3);
                end
            end
            if (c == 5) begin
                total++;
                if (cpu_rdata3 !== 8'h81) begin
                    bad++;
                    $display("FAIL lat3_data: got=%h required=81", cpu_rdata3);
                end
                @(posedge clk); #1 c_req3 = 1'b0;
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        c_req3 = 1'b0; c_we3 = 1'b0; c_addr3 = '0; c_wdata3 = '0;
        l_req3 = 1'b0; l_we3 = 1'b0; l_addr3 = '0; l_wdata3 = '0;
        test_reset();
        test_cpu_write();
        test_ld_read();
        test_back_to_back();
        test_hold_off();
        test_round_robin();
        test_reset_mid_access();
        test_rdlat3();
        repeat (3) @(posedge clk);
        total++;
        if (q1.size() != 0 || q3.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: pending=%0d/%0d required=0/0", q1.size(), q3.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
